// File: rtl/biriscv_multiplier_pipe.sv
`timescale 1ns/1ps
// biriscv_multiplier_pipe
// Parametrised, fully pipelined RV M-extension multiplier covering MUL, MULH,
// MULHSU and MULHU. Every stage carries its own valid bit and destination
// index, so writeback is self-timed. The pipeline also supports hold, flush and
// a busy indication.
//
// XLEN   : operand/result width (32 or 64)
// STAGES : issue-to-writeback latency in cycles (1..4)
//
// Optional macro MULT_PERF_COUNT_EN adds mult_count_o, a wrapping count of
// retired operations.
module biriscv_multiplier_pipe #(
  parameter int XLEN   = 32,
  parameter int STAGES = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            opcode_valid_i,
  input  logic [31:0]     opcode_opcode_i,
  input  logic [4:0]      opcode_rd_idx_i,
  input  logic [XLEN-1:0] opcode_ra_operand_i,
  input  logic [XLEN-1:0] opcode_rb_operand_i,
  input  logic            hold_i,
  input  logic            flush_i,
  output logic            writeback_valid_o,
  output logic [4:0]      writeback_rd_idx_o,
  output logic [XLEN-1:0] writeback_value_o,
  output logic            busy_o
`ifdef MULT_PERF_COUNT_EN
  ,
  output logic [31:0]     mult_count_o
`endif
);

  // Products are formed modulo 2^(2*XLEN). The operands are sign-extended
  // XLEN+1 bit values, so the discarded upper bits of the full signed product
  // never affect either result half.
  localparam int PW = 2 * XLEN;

  logic [2:0]      funct3_w;
  logic            is_mul_w;
  logic            accept_w;
  logic            hi_sel_d;
  logic [XLEN:0]   a_ext_d;
  logic [XLEN:0]   b_ext_d;
  logic            opcode_unused;
  logic [XLEN-1:0] result_w;

  logic            valid_q [STAGES];
  logic            valid_d [STAGES];
  logic [4:0]      rd_q    [STAGES];
  logic [4:0]      rd_d    [STAGES];

  // Multiplies two extended operands and picks the low or high result half.
  function automatic logic [XLEN-1:0] mul_select(input logic [XLEN:0] a,
                                                 input logic [XLEN:0] b,
                                                 input logic          hi);
    logic [PW-1:0] a_w;
    logic [PW-1:0] b_w;
    logic [PW-1:0] prod;
    a_w  = {{(PW-XLEN-1){a[XLEN]}}, a};
    b_w  = {{(PW-XLEN-1){b[XLEN]}}, b};
    prod = a_w * b_w;
    return hi ? prod[PW-1:XLEN] : prod[XLEN-1:0];
  endfunction

  // Decode the instruction word, then sign- or zero-extend the operands.
  // MULH and MULHSU treat rs1 as signed; only MULH treats rs2 as signed.
  always_comb begin
    funct3_w = opcode_opcode_i[14:12];
    is_mul_w = (opcode_opcode_i[6:0] == 7'b0110011) &&
               (opcode_opcode_i[31:25] == 7'b0000001) &&
               !funct3_w[2];
    hi_sel_d = (funct3_w[1:0] != 2'b00);
    a_ext_d  = {((funct3_w[1:0] == 2'b01) || (funct3_w[1:0] == 2'b10)) &
                opcode_ra_operand_i[XLEN-1], opcode_ra_operand_i};
    b_ext_d  = {(funct3_w[1:0] == 2'b01) & opcode_rb_operand_i[XLEN-1],
                opcode_rb_operand_i};
  end

  assign accept_w      = opcode_valid_i & is_mul_w & ~hold_i & ~flush_i;
  assign opcode_unused = ^{opcode_opcode_i[24:15], opcode_opcode_i[11:7]};

  // Next state of the valid/rd tracking chain.
  // Flush kills every valid bit; hold freezes the chain; otherwise it shifts.
  always_comb begin
    for (int i = 0; i < STAGES; i++) begin
      valid_d[i] = valid_q[i];
      rd_d[i]    = rd_q[i];
    end
    if (flush_i) begin
      for (int i = 0; i < STAGES; i++) begin
        valid_d[i] = 1'b0;
      end
    end else if (!hold_i) begin
      valid_d[0] = accept_w;
      rd_d[0]    = opcode_rd_idx_i;
      for (int i = 1; i < STAGES; i++) begin
        valid_d[i] = valid_q[i-1];
        rd_d[i]    = rd_q[i-1];
      end
    end
  end

  // Register the valid/rd tracking chain. Reset clears it completely.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < STAGES; i++) begin
        valid_q[i] <= 1'b0;
        rd_q[i]    <= 5'd0;
      end
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        valid_q[i] <= valid_d[i];
        rd_q[i]    <= rd_d[i];
      end
    end
  end

  if (STAGES == 1) begin : g_single
    logic [XLEN-1:0] res_q;

    // Multiply straight from the issue operands and register the selected half.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        res_q <= '0;
      end else if (!hold_i) begin
        res_q <= mul_select(a_ext_d, b_ext_d, hi_sel_d);
      end
    end

    assign result_w = res_q;
  end else begin : g_multi
    logic [XLEN:0]   a_q;
    logic [XLEN:0]   b_q;
    logic            hi_sel_q;
    logic [XLEN-1:0] res_q [STAGES-1];

    // Stage 1 captures the extended operands and the result-half select.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        a_q      <= '0;
        b_q      <= '0;
        hi_sel_q <= 1'b0;
      end else if (!hold_i) begin
        a_q      <= a_ext_d;
        b_q      <= b_ext_d;
        hi_sel_q <= hi_sel_d;
      end
    end

    // Stage 2 registers the product half; any further stages only delay it.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        for (int i = 0; i < STAGES - 1; i++) begin
          res_q[i] <= '0;
        end
      end else if (!hold_i) begin
        res_q[0] <= mul_select(a_q, b_q, hi_sel_q);
        for (int i = 1; i < STAGES - 1; i++) begin
          res_q[i] <= res_q[i-1];
        end
      end
    end

    assign result_w = res_q[STAGES-2];
  end

  // Qualify the writeback with the valid bit of the last stage.
  always_comb begin
    writeback_valid_o  = valid_q[STAGES-1];
    writeback_rd_idx_o = valid_q[STAGES-1] ? rd_q[STAGES-1] : 5'd0;
    writeback_value_o  = valid_q[STAGES-1] ? result_w : '0;
    busy_o             = 1'b0;
    for (int i = 0; i < STAGES; i++) begin
      busy_o = busy_o | valid_q[i];
    end
  end

`ifdef MULT_PERF_COUNT_EN
  logic [31:0] count_q;

  // Count each retired operation once. A held writeback is only counted when
  // it finally leaves the pipe.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= 32'd0;
    end else if (writeback_valid_o && !hold_i) begin
      count_q <= count_q + 32'd1;
    end
  end

  assign mult_count_o = count_q;
`endif

endmodule

// File: tb/tb_biriscv_multiplier_pipe.sv
`timescale 1ns/1ps
// Testbench for biriscv_multiplier_pipe: a 32-bit/2-stage instance and a
// 64-bit/4-stage instance, with directed scenarios and randomized traffic
// checked against a plain-arithmetic reference model.
module tb_biriscv_multiplier_pipe;

  localparam int NCYC = 300;

  logic clk = 1'b0;
  logic rst;

  logic        nValid, nHold, nFlush;
  logic [31:0] nOp;
  logic [4:0]  nRd;
  logic [31:0] nA, nB;
  logic        nWbv;
  logic [4:0]  nWbRd;
  logic [31:0] nWbVal;
  logic        nBusy;

  logic        wValid, wHold, wFlush;
  logic [31:0] wOp;
  logic [4:0]  wRd;
  logic [63:0] wA, wB;
  logic        wWbv;
  logic [4:0]  wWbRd;
  logic [63:0] wWbVal;
  logic        wBusy;

`ifdef MULT_PERF_COUNT_EN
  logic [31:0] nCnt, wCnt;
`endif

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  biriscv_multiplier_pipe #(.XLEN(32), .STAGES(2)) dut (
    .clk_i(clk), .rst_i(rst),
    .opcode_valid_i(nValid), .opcode_opcode_i(nOp), .opcode_rd_idx_i(nRd),
    .opcode_ra_operand_i(nA), .opcode_rb_operand_i(nB),
    .hold_i(nHold), .flush_i(nFlush),
    .writeback_valid_o(nWbv), .writeback_rd_idx_o(nWbRd),
    .writeback_value_o(nWbVal), .busy_o(nBusy)
`ifdef MULT_PERF_COUNT_EN
    , .mult_count_o(nCnt)
`endif
  );

  biriscv_multiplier_pipe #(.XLEN(64), .STAGES(4)) dutWide (
    .clk_i(clk), .rst_i(rst),
    .opcode_valid_i(wValid), .opcode_opcode_i(wOp), .opcode_rd_idx_i(wRd),
    .opcode_ra_operand_i(wA), .opcode_rb_operand_i(wB),
    .hold_i(wHold), .flush_i(wFlush),
    .writeback_valid_o(wWbv), .writeback_rd_idx_o(wWbRd),
    .writeback_value_o(wWbVal), .busy_o(wBusy)
`ifdef MULT_PERF_COUNT_EN
    , .mult_count_o(wCnt)
`endif
  );

  // Instruction word with the given funct7/funct3 and the OP major opcode
  function automatic logic [31:0] enc(input logic [6:0] f7, input logic [2:0] f3,
                                      input logic [4:0] rdx);
    return {f7, 5'd2, 5'd1, f3, rdx, 7'b0110011};
  endfunction

  // Reference: 32-bit result from 64-bit integer arithmetic
  function automatic logic [31:0] ref32(input logic [1:0] f, input logic [31:0] x,
                                        input logic [31:0] y);
    longint sx, sy, ux, uy;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = longint'({32'd0, x});
    uy = longint'({32'd0, y});
    case (f)
      2'b01:   p = sx * sy;
      2'b10:   p = sx * uy;
      default: p = ux * uy;
    endcase
    return (f == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  // Reference: 64-bit result from 128-bit modular arithmetic
  function automatic logic [63:0] ref64(input logic [1:0] f, input logic [63:0] x,
                                        input logic [63:0] y);
    logic [127:0] sx, sy, ux, uy, p;
    sx = {{64{x[63]}}, x};
    sy = {{64{y[63]}}, y};
    ux = {64'd0, x};
    uy = {64'd0, y};
    case (f)
      2'b01:   p = sx * sy;
      2'b10:   p = sx * uy;
      default: p = ux * uy;
    endcase
    return (f == 2'b00) ? p[63:0] : p[127:64];
  endfunction

  function automatic logic [31:0] pick32();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [63:0] pick64();
    case ($urandom_range(0, 5))
      0:       return 64'h0;
      1:       return 64'hFFFF_FFFF_FFFF_FFFF;
      2:       return 64'h8000_0000_0000_0000;
      3:       return 64'h7FFF_FFFF_FFFF_FFFF;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    nValid = 0; nHold = 0; nFlush = 0; nOp = 0; nRd = 0; nA = 0; nB = 0;
    wValid = 0; wHold = 0; wFlush = 0; wOp = 0; wRd = 0; wA = 0; wB = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (nWbv !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid: got %0b want 0", nWbv); end
    total++; if (nWbRd !== 5'd0) begin bad++; $display("[TB] FAIL reset_rd: got %0d want 0", nWbRd); end
    total++; if (nWbVal !== 32'd0) begin bad++; $display("[TB] FAIL reset_value: got %h want 0", nWbVal); end
    total++; if (nBusy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %0b want 0", nBusy); end
    total++; if (wWbv !== 1'b0 || wBusy !== 1'b0 || wWbVal !== 64'd0) begin
      bad++; $display("[TB] FAIL reset_wide: valid %0b busy %0b value %h want all 0", wWbv, wBusy, wWbVal);
    end
`ifdef MULT_PERF_COUNT_EN
    total++; if (nCnt !== 32'd0) begin bad++; $display("[TB] FAIL reset_count: got %0d want 0", nCnt); end
`endif
  endtask

  task automatic test_mul_basic();
    do_reset();
    nValid = 1; nOp = enc(7'h01, 3'b000, 5'd5); nRd = 5; nA = 32'd7; nB = 32'hFFFF_FFFD;
    tick();
    nValid = 0;
    total++; if (nBusy !== 1'b1) begin bad++; $display("[TB] FAIL mul_busy_c1: got %0b want 1", nBusy); end
    total++; if (nWbv !== 1'b0) begin bad++; $display("[TB] FAIL mul_early_c1: got %0b want 0", nWbv); end
    tick();
    total++; if (nWbv !== 1'b1) begin bad++; $display("[TB] FAIL mul_valid_c2: got %0b want 1", nWbv); end
    total++; if (nWbRd !== 5'd5) begin bad++; $display("[TB] FAIL mul_rd: got %0d want 5", nWbRd); end
    total++; if (nWbVal !== 32'hFFFF_FFEB) begin bad++; $display("[TB] FAIL mul_value: got %h want ffffffeb", nWbVal); end
    total++; if (nBusy !== 1'b1) begin bad++; $display("[TB] FAIL mul_busy_c2: got %0b want 1", nBusy); end
    tick();
    total++; if (nWbv !== 1'b0 || nBusy !== 1'b0 || nWbVal !== 32'd0) begin
      bad++; $display("[TB] FAIL mul_drain_c3: valid %0b busy %0b value %h want 0 0 0", nWbv, nBusy, nWbVal);
    end
`ifdef MULT_PERF_COUNT_EN
    total++; if (nCnt !== 32'd1) begin bad++; $display("[TB] FAIL mul_count: got %0d want 1", nCnt); end
`endif
  endtask

  task automatic test_back_to_back();
    logic [2:0]  f3s  [3] = '{3'b001, 3'b010, 3'b011};
    logic [31:0] as   [3] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] bs   [3] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] exps [3] = '{32'h4000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    do_reset();
    for (int k = 0; k < 5; k++) begin
      if (k < 3) begin
        nValid = 1; nOp = enc(7'h01, f3s[k], 5'(k + 1)); nRd = 5'(k + 1); nA = as[k]; nB = bs[k];
      end else begin
        nValid = 0;
      end
      if (k >= 2) begin
        total++; if (nWbv !== 1'b1 || nWbRd !== 5'(k - 1) || nWbVal !== exps[k-2]) begin
          bad++; $display("[TB] FAIL b2b_%0d: got v=%0b rd=%0d val=%h want v=1 rd=%0d val=%h",
                          k - 2, nWbv, nWbRd, nWbVal, k - 1, exps[k-2]);
        end
      end
      tick();
    end
    total++; if (nWbv !== 1'b0) begin bad++; $display("[TB] FAIL b2b_drain: got %0b want 0", nWbv); end
`ifdef MULT_PERF_COUNT_EN
    total++; if (nCnt !== 32'd3) begin bad++; $display("[TB] FAIL b2b_count: got %0d want 3", nCnt); end
`endif
  endtask

  task automatic test_hold();
    do_reset();
    nValid = 1; nOp = enc(7'h01, 3'b000, 5'd9); nRd = 9; nA = 32'd3; nB = 32'd4;
    tick();
    nValid = 0; nHold = 1;
    for (int k = 1; k <= 4; k++) begin
      if (k == 4) nHold = 0;
      total++; if (nWbv !== 1'b0 || nBusy !== 1'b1) begin
        bad++; $display("[TB] FAIL hold_wait_c%0d: valid %0b busy %0b want 0 1", k, nWbv, nBusy);
      end
      tick();
    end
    nHold = 1;
    for (int k = 5; k <= 7; k++) begin
      if (k == 7) nHold = 0;
      total++; if (nWbv !== 1'b1 || nWbRd !== 5'd9 || nWbVal !== 32'd12) begin
        bad++; $display("[TB] FAIL hold_out_c%0d: got v=%0b rd=%0d val=%h want v=1 rd=9 val=c",
                        k, nWbv, nWbRd, nWbVal);
      end
      tick();
    end
    total++; if (nWbv !== 1'b0) begin bad++; $display("[TB] FAIL hold_release: got %0b want 0", nWbv); end
`ifdef MULT_PERF_COUNT_EN
    total++; if (nCnt !== 32'd1) begin bad++; $display("[TB] FAIL hold_count: got %0d want 1", nCnt); end
`endif
  endtask

  task automatic test_flush();
    do_reset();
    // Wide pipe: two ops in flight, flush the cycle after the second with a
    // third op issued alongside; nothing may ever write back
    wValid = 1; wOp = enc(7'h01, 3'b000, 5'd1); wRd = 1; wA = 64'd2; wB = 64'd3;
    tick();
    wOp = enc(7'h01, 3'b000, 5'd2); wRd = 2; wA = 64'd4; wB = 64'd5;
    tick();
    wOp = enc(7'h01, 3'b000, 5'd3); wRd = 3; wA = 64'd6; wB = 64'd7; wFlush = 1;
    // Narrow pipe: an issue in the same cycle as flush is dropped
    nValid = 1; nOp = enc(7'h01, 3'b000, 5'd4); nRd = 4; nA = 32'd8; nB = 32'd9; nFlush = 1;
    tick();
    idle_inputs();
    total++; if (wBusy !== 1'b0) begin bad++; $display("[TB] FAIL flush_busy_wide: got %0b want 0", wBusy); end
    total++; if (nBusy !== 1'b0) begin bad++; $display("[TB] FAIL flush_busy_narrow: got %0b want 0", nBusy); end
    for (int k = 0; k < 6; k++) begin
      total++; if (wWbv !== 1'b0 || nWbv !== 1'b0) begin
        bad++; $display("[TB] FAIL flush_no_wb_%0d: wide %0b narrow %0b want 0 0", k, wWbv, nWbv);
      end
      tick();
    end
`ifdef MULT_PERF_COUNT_EN
    total++; if (wCnt !== 32'd0) begin bad++; $display("[TB] FAIL flush_count: got %0d want 0", wCnt); end
`endif
  endtask

  task automatic test_nonmul();
    logic [31:0] ops [3];
    ops[0] = enc(7'h01, 3'b100, 5'd6);
    ops[1] = enc(7'h00, 3'b000, 5'd6);
    ops[2] = enc(7'h01, 3'b111, 5'd6);
    do_reset();
    for (int k = 0; k < 6; k++) begin
      if (k < 3) begin
        nValid = 1; nOp = ops[k]; nRd = 6; nA = 32'd10; nB = 32'd11;
      end else begin
        nValid = 0;
      end
      tick();
      total++; if (nWbv !== 1'b0 || nBusy !== 1'b0) begin
        bad++; $display("[TB] FAIL nonmul_%0d: valid %0b busy %0b want 0 0", k, nWbv, nBusy);
      end
    end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    nValid = 1; nOp = enc(7'h01, 3'b000, 5'd4); nRd = 4; nA = 32'd5; nB = 32'd6;
    tick();
    nValid = 0;
    total++; if (nBusy !== 1'b1) begin bad++; $display("[TB] FAIL midrst_busy: got %0b want 1", nBusy); end
    rst = 1;
    tick();
    rst = 0;
    total++; if (nWbv !== 1'b0 || nWbRd !== 5'd0 || nWbVal !== 32'd0 || nBusy !== 1'b0) begin
      bad++; $display("[TB] FAIL midrst_outputs: v=%0b rd=%0d val=%h busy=%0b want all 0",
                      nWbv, nWbRd, nWbVal, nBusy);
    end
    tick();
    total++; if (nWbv !== 1'b0) begin bad++; $display("[TB] FAIL midrst_lost: got %0b want 0", nWbv); end
  endtask

  task automatic test_wide();
    do_reset();
    wValid = 1; wOp = enc(7'h01, 3'b011, 5'd7); wRd = 7;
    wA = 64'hFFFF_FFFF_FFFF_FFFF; wB = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    wValid = 0;
    for (int k = 1; k <= 3; k++) begin
      total++; if (wWbv !== 1'b0 || wBusy !== 1'b1) begin
        bad++; $display("[TB] FAIL wide_wait_c%0d: valid %0b busy %0b want 0 1", k, wWbv, wBusy);
      end
      tick();
    end
    total++; if (wWbv !== 1'b1 || wWbRd !== 5'd7 || wWbVal !== 64'hFFFF_FFFF_FFFF_FFFE) begin
      bad++; $display("[TB] FAIL wide_mulhu: got v=%0b rd=%0d val=%h want v=1 rd=7 val=fffffffffffffffe",
                      wWbv, wWbRd, wWbVal);
    end
    tick();
    total++; if (wWbv !== 1'b0) begin bad++; $display("[TB] FAIL wide_drain: got %0b want 0", wWbv); end
`ifdef MULT_PERF_COUNT_EN
    total++; if (wCnt !== 32'd1) begin bad++; $display("[TB] FAIL wide_count: got %0d want 1", wCnt); end
`endif
  endtask

  task automatic test_random();
    logic        nExpV [NCYC + 8];
    logic [4:0]  nExpRd [NCYC + 8];
    logic [31:0] nExpVal [NCYC + 8];
    logic        wExpV [NCYC + 8];
    logic [4:0]  wExpRd [NCYC + 8];
    logic [63:0] wExpVal [NCYC + 8];
    int nRetired = 0;
    int wRetired = 0;
    for (int i = 0; i < NCYC + 8; i++) begin
      nExpV[i] = 0; nExpRd[i] = 0; nExpVal[i] = 0;
      wExpV[i] = 0; wExpRd[i] = 0; wExpVal[i] = 0;
    end
    do_reset();
    for (int c = 0; c < NCYC + 4; c++) begin
      if (c < NCYC) begin
        int kind;
        logic [1:0] f;
        // Narrow instance stimulus
        kind = $urandom_range(0, 9);
        f = 2'($urandom_range(0, 3));
        nRd = 5'($urandom); nA = pick32(); nB = pick32();
        nValid = (kind >= 2);
        if (kind == 2) nOp = enc(7'h01, {1'b1, f}, nRd);
        else if (kind == 3) nOp = enc(7'h00, {1'b0, f}, nRd);
        else nOp = enc(7'h01, {1'b0, f}, nRd);
        if (kind >= 4) begin
          nExpV[c + 2] = 1; nExpRd[c + 2] = nRd; nExpVal[c + 2] = ref32(f, nA, nB);
          nRetired++;
        end
        // Wide instance stimulus
        kind = $urandom_range(0, 9);
        f = 2'($urandom_range(0, 3));
        wRd = 5'($urandom); wA = pick64(); wB = pick64();
        wValid = (kind >= 2);
        if (kind == 2) wOp = enc(7'h01, {1'b1, f}, wRd);
        else if (kind == 3) wOp = {$urandom, 7'b0010011};
        else wOp = enc(7'h01, {1'b0, f}, wRd);
        if (kind == 3) wOp[6:0] = 7'b0010011;
        if (kind >= 4) begin
          wExpV[c + 4] = 1; wExpRd[c + 4] = wRd; wExpVal[c + 4] = ref64(f, wA, wB);
          wRetired++;
        end
      end else begin
        nValid = 0; wValid = 0;
      end
      total++; if (nWbv !== nExpV[c] || nWbRd !== nExpRd[c] || nWbVal !== nExpVal[c]) begin
        bad++; $display("[TB] FAIL rand_narrow_c%0d: got v=%0b rd=%0d val=%h want v=%0b rd=%0d val=%h",
                        c, nWbv, nWbRd, nWbVal, nExpV[c], nExpRd[c], nExpVal[c]);
      end
      total++; if (wWbv !== wExpV[c] || wWbRd !== wExpRd[c] || wWbVal !== wExpVal[c]) begin
        bad++; $display("[TB] FAIL rand_wide_c%0d: got v=%0b rd=%0d val=%h want v=%0b rd=%0d val=%h",
                        c, wWbv, wWbRd, wWbVal, wExpV[c], wExpRd[c], wExpVal[c]);
      end
      tick();
    end
`ifdef MULT_PERF_COUNT_EN
    total++; if (nCnt !== 32'(nRetired)) begin bad++; $display("[TB] FAIL rand_count_narrow: got %0d want %0d", nCnt, nRetired); end
    total++; if (wCnt !== 32'(wRetired)) begin bad++; $display("[TB] FAIL rand_count_wide: got %0d want %0d", wCnt, wRetired); end
`else
    if (nRetired + wRetired == 0) $display("[TB] note: random run issued no multiplies");
`endif
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    test_reset();
    test_mul_basic();
    test_back_to_back();
    test_hold();
    test_flush();
    test_nonmul();
    test_reset_midflight();
    test_wide();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/biriscv_multiplier_pipe.md
Name: biriscv_multiplier_pipe

Overview:
- Parametrised, fully pipelined RV M-extension multiplier (MUL, MULH, MULHSU, MULHU) for the execute pipe.
- Generalises the fixed 32-bit, fixed-depth multiplier in width (XLEN) and depth (STAGES).
- Adds per-stage valid and destination-register tracking, flush, and a busy indication, so writeback is self-timed rather than inferred by the issue logic.
- Accepts one operation per cycle.

Parameters:
XLEN, 32, operand/result width; legal values 32 or 64.
STAGES, 2, issue-to-writeback latency in cycles; legal values 1..4.

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, synchronous, active-high
opcode_valid_i  in  1  issue strobe
opcode_opcode_i  in  32  raw instruction word
opcode_rd_idx_i  in  5  destination register index
opcode_ra_operand_i  in  XLEN  rs1 value
opcode_rb_operand_i  in  XLEN  rs2 value
hold_i  in  1  pipeline stall; freezes all stages
flush_i  in  1  kill every in-flight operation
writeback_valid_o  out  1  result valid this cycle
writeback_rd_idx_o  out  5  destination of result
writeback_value_o  out  XLEN  result
busy_o  out  1  any stage holds a valid operation

Behaviour:
- Decode: an operation is a multiply when opcode[6:0]=0110011 and funct7=0000001.
  - funct3 000 = MUL, 001 = MULH, 010 = MULHSU, 011 = MULHU.
  - funct3 1xx (divide ops) and all other opcodes are not multiplies.
- Accept: opcode_valid_i & is_mul & ~hold_i & ~flush_i.
  - A non-multiply with opcode_valid_i high is ignored: no state change, no writeback.
- Operand extension to XLEN+1 bits:
  - MULH: a signed, b signed.
  - MULHSU: a signed, b zero-extended.
  - MULHU and MUL: both zero-extended.
  - Signed product is 2*XLEN+2 bits.
  - MUL returns product[XLEN-1:0]; the three MULH variants return product[2*XLEN-1:XLEN].
- Pipeline:
  - Each stage holds {valid, rd_idx, hi_sel or result}.
  - STAGES=1: product computed from the inputs and the selected result registered at accept.
  - STAGES>=2: stage 1 registers the extended operands, the rd index and hi_sel. Stage 2 registers the selected product half. Stages 3..STAGES are delay registers.
  - Latency is exactly STAGES cycles from the accept edge to writeback_valid_o with hold_i low.
  - Throughput is 1 op/cycle; back-to-back accepts produce back-to-back writebacks in issue order.
- Hold: while hold_i=1, every stage register (valid, rd, data) retains its value and no new op is accepted. Outputs stay stable, so a valid writeback is presented for every held cycle.
- Flush: flush_i=1 clears all valid bits at the next edge.
  - Has priority over hold_i and over a same-cycle issue, which is dropped.
  - Data registers may keep stale contents.
- Bubbles: when no op is accepted and hold_i=0, a valid=0 entry enters stage 1.
- Outputs:
  - writeback_valid_o = valid bit of the last stage.
  - writeback_rd_idx_o and writeback_value_o are forced to 0 whenever writeback_valid_o=0.
  - busy_o = OR of all stage valid bits (combinational from registers).
- Reset (rst_i at the clock edge): all valid bits, rd indices and data registers go to 0.
  - writeback_valid_o=0, writeback_rd_idx_o=0, writeback_value_o=0, busy_o=0 from the first post-reset cycle.
  - Reset overrides hold_i, flush_i and issue.
  - In-flight operations at reset are discarded with no writeback.

Optional Feature:
- Macro MULT_PERF_COUNT_EN.
- Defined: adds output mult_count_o[31:0], reset to 0, incremented by 1 on each cycle where writeback_valid_o=1 and hold_i=0 (once per retired op). Wraps 0xFFFFFFFF -> 0. Flushed ops are not counted.
- Undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
- XLEN=32, STAGES=2: MUL rd=5, a=7, b=0xFFFFFFFD -> exactly 2 cycles later: writeback_valid_o=1, rd=5, value=0xFFFFFFEB; busy_o=1 for those 2 cycles.
- MULH a=b=0x80000000 -> 0x40000000. MULHSU a=0xFFFFFFFF, b=0xFFFFFFFF -> 0xFFFFFFFF. MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE. Issue all three on consecutive cycles -> three consecutive writebacks in order.
- Issue MUL 3*4, then hold_i=1 for 3 cycles starting the cycle after issue -> writeback 12 appears at cycle 2+3. If hold is asserted while the result is at the output, the result stays valid and stable for every held cycle.
- Issue two MULs, assert flush_i on the cycle after the second -> no writeback ever. A MUL issued in the same cycle as flush_i is dropped. busy_o=0 one cycle after flush.
- opcode_valid_i=1 with a DIV encoding (funct3=100) or ADD -> no writeback. Assert rst_i mid-flight -> outputs 0 next cycle, in-flight op lost.
- XLEN=64, STAGES=4: MULHU a=b=0xFFFFFFFFFFFFFFFF -> value 0xFFFFFFFFFFFFFFFE after 4 cycles. With MULT_PERF_COUNT_EN, mult_count_o=1 afterwards.
